// File: rtl/tt_sweep_checker.sv
// Sweep checker for a 3-input combinational block: drives {x3,x2,x1} = 0..7,
// samples f after a settle time, and reports per-vector mismatches.
module tt_sweep_checker #(
    parameter logic [7:0]  EXPECTED = 8'b1110_1000,
    parameter int unsigned SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f,
    output logic       x3,
    output logic       x2,
    output logic       x1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_mask,
    output logic [3:0] err_count,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [2:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  x_q, x_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [7:0]  fail_mask_q, fail_mask_d;
    logic [3:0]  err_count_q, err_count_d;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    vec_d       = 3'd0;
                    cnt_d       = 4'd0;
                    x_d         = 3'd0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_mask_d = 8'h00;
                    err_count_d = 4'd0;
                end
            end
            RUN: begin
                if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    if (f != EXPECTED[vec_q]) begin
                        fail_mask_d[vec_q] = 1'b1;
                        err_count_d        = err_count_q + 4'd1;
                    end
                    if (vec_q == 3'd7) begin
                        // pass must include the mismatch recorded on this very edge
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        x_d     = 3'd0;
                        pass_d  = (fail_mask_d == 8'h00);
                    end else begin
                        vec_d = vec_q + 3'd1;
                        cnt_d = 4'd0;
                        x_d   = vec_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                x_d     = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= 3'd0;
            cnt_q       <= 4'd0;
            x_q         <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 8'h00;
            err_count_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
        end
    end

    assign {x3, x2, x1} = x_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_mask    = fail_mask_q;
    assign err_count    = err_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: a default-SETTLE instance and a SETTLE=0
// instance, each driven by a behavioural majority/zero/inverted-majority block.
module tb_tt_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start0, start1;
    int         mode;
    logic       x3_0, x2_0, x1_0, busy0, done0, pass0;
    logic       x3_1, x2_1, x1_1, busy1, done1, pass1;
    logic [7:0] mask0, mask1;
    logic [3:0] err0, err1;
    logic [1:0] st0, st1;
    logic       f0, f1;
    int         n_checks;
    int         n_errors;

    function automatic logic model_f(input int m, input logic a, input logic b, input logic c);
        logic maj;
        maj = (a & b) | (a & c) | (b & c);
        if (m == 1) return 1'b0;
        if (m == 2) return ~maj;
        return maj;
    endfunction

    assign f0 = model_f(mode, x3_0, x2_0, x1_0);
    assign f1 = model_f(mode, x3_1, x2_1, x1_1);

    tt_sweep_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .f(f0),
        .x3(x3_0), .x2(x2_0), .x1(x1_0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(mask0), .err_count(err0), .dbg_state(st0)
    );

    tt_sweep_checker #(.EXPECTED(8'hE8), .SETTLE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f(f1),
        .x3(x3_1), .x2(x2_1), .x1(x1_1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(mask1), .err_count(err1), .dbg_state(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({x3_0, x2_0, x1_0, busy0, done0, pass0, mask0, err0} !== 18'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got x=%b busy=%b done=%b pass=%b mask=%h err=%0d want all 0",
                     {x3_0, x2_0, x1_0}, busy0, done0, pass0, mask0, err0);
        end
        n_checks++;
        if (st0 !== 2'd0 || st1 !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state got %0d/%0d want 0/0", st0, st1);
        end
        #2 rst_n = 1'b1;
        step();
    endtask

    // Start at edge 0, then check every cycle through the DONE cycle and the return to IDLE.
    task automatic run_sweep(input int m, input logic [7:0] exp_mask, input logic [3:0] exp_err,
                             input logic exp_pass, input string name);
        mode   = m;
        start0 = 1'b1;
        for (int i = 0; i <= 24; i++) begin
            step();
            start0 = 1'b0;
            if (i < 24) begin
                n_checks++;
                if ({x3_0, x2_0, x1_0} !== 3'(i / 3) || busy0 !== 1'b1 || done0 !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s_run_c%0d got x=%0d busy=%b done=%b want x=%0d busy=1 done=0",
                             name, i, {x3_0, x2_0, x1_0}, busy0, done0, i / 3);
                end
            end else begin
                n_checks++;
                if (done0 !== 1'b1 || busy0 !== 1'b0 || {x3_0, x2_0, x1_0} !== 3'd0) begin
                    n_errors++;
                    $display("FAIL %s_done got done=%b busy=%b x=%0d want done=1 busy=0 x=0",
                             name, done0, busy0, {x3_0, x2_0, x1_0});
                end
                n_checks++;
                if (mask0 !== exp_mask || err0 !== exp_err || pass0 !== exp_pass) begin
                    n_errors++;
                    $display("FAIL %s_result got mask=%h err=%0d pass=%b want mask=%h err=%0d pass=%b",
                             name, mask0, err0, pass0, exp_mask, exp_err, exp_pass);
                end
            end
        end
        step();
        n_checks++;
        if (done0 !== 1'b0 || st0 !== 2'd0 || mask0 !== exp_mask || err0 !== exp_err || pass0 !== exp_pass) begin
            n_errors++;
            $display("FAIL %s_idle_hold got done=%b state=%0d mask=%h err=%0d pass=%b want done=0 state=0 results held",
                     name, done0, st0, mask0, err0, pass0);
        end
    endtask

    task automatic test_majority();
        run_sweep(0, 8'h00, 4'd0, 1'b1, "majority");
    endtask

    task automatic test_stuck_zero();
        run_sweep(1, 8'hE8, 4'd4, 1'b0, "stuck0");
    endtask

    task automatic test_inverted();
        run_sweep(2, 8'hFF, 4'd8, 1'b0, "inverted");
    endtask

    task automatic test_back_to_back();
        int dones;
        dones  = 0;
        mode   = 1;
        start0 = 1'b1;
        for (int i = 0; i <= 52; i++) begin
            step();
            if (done0 === 1'b1) dones++;
            if (i == 25) begin
                n_checks++;
                if (st0 !== 2'd0 || busy0 !== 1'b0 || dones != 1) begin
                    n_errors++;
                    $display("FAIL b2b_ignore_in_done got state=%0d busy=%b dones=%0d want 0 0 1", st0, busy0, dones);
                end
            end
            if (i == 26) begin
                mode = 0;
                n_checks++;
                if (busy0 !== 1'b1 || mask0 !== 8'h00 || err0 !== 4'd0 || pass0 !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_restart got busy=%b mask=%h err=%0d pass=%b want 1 00 0 0",
                             busy0, mask0, err0, pass0);
                end
            end
            if (i == 50) begin
                start0 = 1'b0;
                n_checks++;
                if (done0 !== 1'b1 || pass0 !== 1'b1 || mask0 !== 8'h00) begin
                    n_errors++;
                    $display("FAIL b2b_second_done got done=%b pass=%b mask=%h want 1 1 00", done0, pass0, mask0);
                end
            end
        end
        n_checks++;
        if (dones != 2 || st0 !== 2'd0 || busy0 !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_done_count got dones=%0d state=%0d busy=%b want 2 0 0", dones, st0, busy0);
        end
    endtask

    task automatic test_reset_mid();
        mode   = 1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 1; i <= 13; i++) step();
        n_checks++;
        if ({x3_0, x2_0, x1_0} !== 3'd4 || err0 !== 4'd1 || mask0 !== 8'h08) begin
            n_errors++;
            $display("FAIL midrst_pre got x=%0d err=%0d mask=%h want 4 1 08", {x3_0, x2_0, x1_0}, err0, mask0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({x3_0, x2_0, x1_0, busy0, done0, pass0, mask0, err0} !== 18'd0 || st0 !== 2'd0) begin
            n_errors++;
            $display("FAIL midrst_clear got x=%b busy=%b mask=%h err=%0d state=%0d want all 0",
                     {x3_0, x2_0, x1_0}, busy0, mask0, err0, st0);
        end
        #3 rst_n = 1'b1;
        step();
        run_sweep(0, 8'h00, 4'd0, 1'b1, "after_rst");
    endtask

    task automatic test_settle0(input int m, input logic [7:0] exp_mask, input logic [3:0] exp_err,
                                input logic exp_pass);
        mode   = m;
        start1 = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            step();
            start1 = 1'b0;
            if (i < 8) begin
                n_checks++;
                if ({x3_1, x2_1, x1_1} !== 3'(i) || busy1 !== 1'b1 || done1 !== 1'b0) begin
                    n_errors++;
                    $display("FAIL settle0_m%0d_c%0d got x=%0d busy=%b done=%b want x=%0d busy=1 done=0",
                             m, i, {x3_1, x2_1, x1_1}, busy1, done1, i);
                end
            end else begin
                n_checks++;
                if (done1 !== 1'b1 || mask1 !== exp_mask || err1 !== exp_err || pass1 !== exp_pass) begin
                    n_errors++;
                    $display("FAIL settle0_m%0d_done got done=%b mask=%h err=%0d pass=%b want 1 %h %0d %b",
                             m, done1, mask1, err1, pass1, exp_mask, exp_err, exp_pass);
                end
            end
        end
        step();
        n_checks++;
        if (done1 !== 1'b0 || st1 !== 2'd0) begin
            n_errors++;
            $display("FAIL settle0_m%0d_idle got done=%b state=%0d want 0 0", m, done1, st1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        mode     = 0;
        #1 rst_n = 1'b0;
        test_reset();
        test_majority();
        test_stuck_zero();
        test_inverted();
        test_back_to_back();
        test_reset_mid();
        test_settle0(0, 8'h00, 4'd0, 1'b1);
        test_settle0(2, 8'hFF, 4'd8, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
